// File: rtl/xc20xx_cfg_loader.sv
// ============================================================================
// xc20xx_cfg_loader
// Serial configuration loader for the XC20XX fabric model.
//
// The loader takes one bitstream bit per enabled clock. It hunts for the
// preamble, reads a 24-bit length count, and checks the sync word. It then
// receives NUM_FRAMES framed data words (start bit, FRAME_BITS data bits,
// three stop bits), and finally checks the postamble. Each completed frame is
// presented once on FRAME_DATA/FRAME_ADDR with a one-cycle FRAME_VALID
// pulse. DONE and ERR are sticky until R.
//
// Build option:
//   XC20XX_CFG_LENGTH_CHECK_EN - when defined, the number of bits from the
//   first length bit to the last postamble bit must equal the received
//   length count, otherwise the stream is rejected. When undefined, the
//   length field is consumed and ignored.
// ============================================================================
module xc20xx_cfg_loader #(
   parameter int FRAME_BITS = 71,
   parameter int NUM_FRAMES = 160,
   parameter int ADDR_W     = 8
) (
   input  logic                  K,
   input  logic                  R,
   input  logic                  EN,
   input  logic                  DIN,
   output logic [FRAME_BITS-1:0] FRAME_DATA,
   output logic [ADDR_W-1:0]     FRAME_ADDR,
   output logic                  FRAME_VALID,
   output logic                  DONE,
   output logic                  ERR
);

   // One shared field counter covers the 24-bit length field and the data field.
   localparam int SUB_MAX = (FRAME_BITS > 24) ? FRAME_BITS : 24;
   localparam int CNT_W   = $clog2(SUB_MAX);

   localparam logic [CNT_W-1:0]  SUB_ZERO      = CNT_W'(0);
   localparam logic [CNT_W-1:0]  SUB_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0]  SUB_LEN_LAST  = CNT_W'(23);
   localparam logic [CNT_W-1:0]  SUB_SYNC_LAST = CNT_W'(3);
   localparam logic [CNT_W-1:0]  SUB_DATA_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]  SUB_STOP_LAST = CNT_W'(2);
   localparam logic [CNT_W-1:0]  SUB_POST_LAST = CNT_W'(3);
   localparam logic [ADDR_W-1:0] LAST_FRAME    = ADDR_W'(NUM_FRAMES - 1);

   typedef enum logic [3:0] {
      ST_HUNT  = 4'd0,
      ST_LEN   = 4'd1,
      ST_SYNC  = 4'd2,
      ST_START = 4'd3,
      ST_DATA  = 4'd4,
      ST_STOP  = 4'd5,
      ST_POST  = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERROR = 4'd8
   } state_t;

   state_t                state_q, state_d;
   // Three previous bits; the newest bit of the 4-bit preamble window is DIN itself.
   logic [2:0]            hist_q, hist_d;
   logic [CNT_W-1:0]      sub_q, sub_d;
   logic [FRAME_BITS-1:0] frame_sr_q, frame_sr_d;
   logic [ADDR_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
   logic [ADDR_W-1:0]     frame_addr_q, frame_addr_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  post_bit_ok;

`ifdef XC20XX_CFG_LENGTH_CHECK_EN
   logic [23:0]           len_q, len_d;
   logic [23:0]           bitcnt_q, bitcnt_d;

   // True when the running bit count (including the bit being consumed) matches LENGTH.
   function automatic logic length_ok(input logic [23:0] cnt_before, input logic [23:0] len);
      return ((cnt_before + 24'd1) == len);
   endfunction
`endif

   assign FRAME_DATA  = frame_data_q;
   assign FRAME_ADDR  = frame_addr_q;
   assign FRAME_VALID = frame_valid_q;
   assign DONE        = done_q;
   assign ERR         = err_q;

   // Postamble is 0,1,1,1: only the first postamble bit is expected to be 0.
   assign post_bit_ok = (sub_q == SUB_ZERO) ? (DIN == 1'b0) : (DIN == 1'b1);

   // Next-state and output logic; everything holds unless an enabled bit is consumed.
   always_comb begin
      state_d       = state_q;
      hist_d        = hist_q;
      sub_d         = sub_q;
      frame_sr_d    = frame_sr_q;
      frame_cnt_d   = frame_cnt_q;
      frame_data_d  = frame_data_q;
      frame_addr_d  = frame_addr_q;
      frame_valid_d = 1'b0;
      done_d        = done_q;
      err_d         = err_q;
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
      len_d         = len_q;
      bitcnt_d      = bitcnt_q;
`endif

      if (EN) begin
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
         // Every accepted bit from the first length bit to the last postamble bit counts.
         if ((state_q == ST_LEN) || (state_q == ST_SYNC) || (state_q == ST_START) ||
             (state_q == ST_DATA) || (state_q == ST_STOP) || (state_q == ST_POST)) begin
            bitcnt_d = bitcnt_q + 24'd1;
         end else begin
            bitcnt_d = bitcnt_q;
         end
`endif
         case (state_q)
            ST_HUNT: begin
               hist_d = {hist_q[1:0], DIN};
               if ({hist_q, DIN} == 4'b0010) begin
                  state_d = ST_LEN;
                  sub_d   = SUB_ZERO;
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
                  bitcnt_d = 24'd0;
`endif
               end else begin
                  state_d = ST_HUNT;
               end
            end

            ST_LEN: begin
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
               len_d = {len_q[22:0], DIN};
`endif
               if (sub_q == SUB_LEN_LAST) begin
                  state_d = ST_SYNC;
                  sub_d   = SUB_ZERO;
               end else begin
                  sub_d = sub_q + SUB_ONE;
               end
            end

            ST_SYNC: begin
               if (DIN != 1'b1) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (sub_q == SUB_SYNC_LAST) begin
                  state_d = ST_START;
                  sub_d   = SUB_ZERO;
               end else begin
                  sub_d = sub_q + SUB_ONE;
               end
            end

            ST_START: begin
               if (DIN != 1'b0) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_DATA;
                  sub_d   = SUB_ZERO;
               end
            end

            ST_DATA: begin
               frame_sr_d = {frame_sr_q[FRAME_BITS-2:0], DIN};
               if (sub_q == SUB_DATA_LAST) begin
                  state_d = ST_STOP;
                  sub_d   = SUB_ZERO;
               end else begin
                  sub_d = sub_q + SUB_ONE;
               end
            end

            ST_STOP: begin
               if (DIN != 1'b1) begin
                  // A frame with broken stop bits is dropped, never presented.
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (sub_q == SUB_STOP_LAST) begin
                  frame_data_d  = frame_sr_q;
                  frame_addr_d  = frame_cnt_q;
                  frame_valid_d = 1'b1;
                  frame_cnt_d   = frame_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  sub_d         = SUB_ZERO;
                  if (frame_cnt_q == LAST_FRAME) begin
                     state_d = ST_POST;
                  end else begin
                     state_d = ST_START;
                  end
               end else begin
                  sub_d = sub_q + SUB_ONE;
               end
            end

            ST_POST: begin
               if (!post_bit_ok) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (sub_q == SUB_POST_LAST) begin
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
                  if (length_ok(bitcnt_q, len_q)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ERROR;
                     err_d   = 1'b1;
                  end
`else
                  state_d = ST_DONE;
                  done_d  = 1'b1;
`endif
               end else begin
                  sub_d = sub_q + SUB_ONE;
               end
            end

            ST_DONE: begin
               state_d = ST_DONE;
            end

            ST_ERROR: begin
               state_d = ST_ERROR;
            end

            default: begin
               // Unreachable encodings are treated as a corrupted load.
               state_d = ST_ERROR;
               err_d   = 1'b1;
               done_d  = 1'b0;
            end
         endcase
      end else begin
         // No bit offered: only the FRAME_VALID pulse is allowed to drop.
         frame_valid_d = 1'b0;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge K or posedge R) begin
      if (R) begin
         state_q       <= ST_HUNT;
         hist_q        <= 3'b000;
         sub_q         <= SUB_ZERO;
         frame_sr_q    <= {FRAME_BITS{1'b0}};
         frame_cnt_q   <= {ADDR_W{1'b0}};
         frame_data_q  <= {FRAME_BITS{1'b0}};
         frame_addr_q  <= {ADDR_W{1'b0}};
         frame_valid_q <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
         len_q         <= 24'd0;
         bitcnt_q      <= 24'd0;
`endif
      end else begin
         state_q       <= state_d;
         hist_q        <= hist_d;
         sub_q         <= sub_d;
         frame_sr_q    <= frame_sr_d;
         frame_cnt_q   <= frame_cnt_d;
         frame_data_q  <= frame_data_d;
         frame_addr_q  <= frame_addr_d;
         frame_valid_q <= frame_valid_d;
         done_q        <= done_d;
         err_q         <= err_d;
`ifdef XC20XX_CFG_LENGTH_CHECK_EN
         len_q         <= len_d;
         bitcnt_q      <= bitcnt_d;
`endif
      end
   end

endmodule

// File: doc/xc20xx_cfg_loader.md
# xc20xx_cfg_loader

Serial configuration loader for the XC20XX fabric model. It accepts the device bitstream one bit per enabled clock: preamble, 24-bit length count, then framed configuration data, then postamble. It checks the framing, assembles each data frame and presents it with its frame address, one frame at a time, to the configuration-memory writer that sets CLB LUT, mux and storage-element bits. It signals completion or a format error.

## Interface
Parameters:
- FRAME_BITS, 71, data bits per frame (≥2)
- NUM_FRAMES, 160, frames per bitstream (≥1)
- ADDR_W, 8, width of FRAME_ADDR (2^ADDR_W ≥ NUM_FRAMES)

Ports:
- K  input  1  clock; all state changes on rising edge
- R  input  1  reset; asynchronous, active-high
- EN  input  1  DIN qualifier; a bit is consumed only on edges with EN=1
- DIN  input  1  serial bitstream bit
- FRAME_DATA  output  FRAME_BITS  last completed frame; first received data bit in MSB
- FRAME_ADDR  output  ADDR_W  index of the frame in FRAME_DATA, 0-based
- FRAME_VALID  output  1  one-cycle pulse: FRAME_DATA/FRAME_ADDR hold a new frame
- DONE  output  1  bitstream accepted; sticky until R
- ERR  output  1  format error; sticky until R

## Operation
- States: HUNT, LEN, SYNC, START, DATA, STOP, POST, DONE, ERROR. All consumption below is per accepted bit (EN=1).
- HUNT: shift DIN into a 4-bit history. When the last four bits are 0,0,1,0 in arrival order, go to LEN. Leading 1s and any other garbage are ignored.
- LEN: capture 24 bits MSB-first into LENGTH. Then go to SYNC.
- SYNC: 4 bits, each must be 1. Then go to START.
- START: bit must be 0. Then go to DATA.
- DATA: FRAME_BITS bits shifted into an internal frame register, MSB-first. Then go to STOP.
- STOP: 3 bits, each must be 1. On the third stop bit:
  - copy the frame register to FRAME_DATA;
  - drive FRAME_ADDR = frame counter;
  - pulse FRAME_VALID;
  - increment the frame counter;
  - go to START, or to POST if NUM_FRAMES frames are done.
- POST: 4 bits, must be 0,1,1,1. Then go to DONE.
- DONE: set DONE and ignore DIN.
- Any mismatched bit in SYNC, START, STOP or POST: go to ERROR, set ERR and ignore DIN. A frame whose stop bits failed is never presented.
- Bit counter: 24-bit, cleared on entering LEN. It counts every accepted bit from the first length bit through the last postamble bit inclusive. Total = 24 + 4 + NUM_FRAMES·(FRAME_BITS+4) + 4.
- DONE and ERR are never both 1. Only R leaves DONE or ERROR.

## Timing
- Reset values: FRAME_DATA=0, FRAME_ADDR=0, FRAME_VALID=0, DONE=0, ERR=0. State=HUNT, counters and history cleared.
- All outputs are registered.
- FRAME_VALID is high for exactly the one cycle after the edge that accepts the third stop bit. It is cleared on the next edge even if EN=0.
- FRAME_DATA and FRAME_ADDR hold their values until the next frame completes.
- DONE and ERR rise the cycle after the edge that accepts the deciding bit.
- EN=0: no state, counter or data change except the FRAME_VALID clear.
- Minimum spacing between FRAME_VALID pulses is FRAME_BITS+4 cycles.
- R asserted mid-stream: immediate return to reset values. A frame that is only partly received is discarded.

## Configuration
- XC20XX_CFG_LENGTH_CHECK_EN defined: at the last postamble bit, the bit counter is compared with LENGTH.
  - Equal: DONE.
  - Different: ERROR, even if the postamble is correct.
- Not defined: LENGTH is consumed and ignored, and the bit counter may be omitted. DONE depends only on framing.

## Test plan
The first four scenarios use FRAME_BITS=4, NUM_FRAMES=2, macro defined, so the total count is 48.
- Leading 1111, then 0010, length 48, 1111, frames 0 1011 111 and 0 0110 111, then postamble 0111 -> FRAME_VALID pulses with (1011, addr 0) then (0110, addr 1); DONE=1 the cycle after the last bit; ERR=0.
- Same stream with EN toggled low on every other cycle -> identical outputs. Each pulse is one cycle wide, and completion is delayed by the number of EN=0 cycles.
- Frame 1 stop bits sent as 101 -> no second FRAME_VALID; ERR=1 the cycle after the 0 stop bit; DONE stays 0; later DIN is ignored.
- Length field set to 47, framing otherwise correct -> ERR=1 after the postamble. Repeat with the macro undefined -> DONE=1.
- R pulsed asynchronously during the DATA bits of frame 0, then the full valid stream resent -> all outputs 0 immediately after R. The resent stream then completes normally with addresses 0 and 1.
- Default parameters (71×160), random frame data with the correct length count -> 160 pulses at spacing ≥75 cycles, each FRAME_DATA matching the scoreboard, and DONE at the end.
